ifetch_unit: RTL and testbench

Instruction-fetch requester that drives the 10-bit word address of the synchronous-read instruction memory and consumes its 32-bit output. It owns the fetch PC and hides the memory's one-cycle read latency behind a 2-entry output buffer. It presents instructions to the decode stage over a valid/ready handshake and accepts branch/jump redirects. It sits between IMEM and the decode stage of the MIPS pipeline.

---
 rtl/ifetch_unit.sv | 92 +++++++++
 tb/tb_ifetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch requester: owns the fetch PC, drives a 1-cycle synchronous IMEM,
// and hides the read latency behind a 2-entry {instr, pc} buffer feeding decode.
module ifetch_unit #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_dout,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [31:0]       instr_pc
);

   localparam int unsigned DEPTH = 2;

   logic [31:0]       fetch_pc;
   logic              inflight_valid;
   logic [31:0]       inflight_pc;
   logic [DATA_W-1:0] fifo_instr [DEPTH];
   logic [31:0]       fifo_pc    [DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;

   logic              deq;
   logic              push;
   logic              issue;
   logic [2:0]        occupancy;
   logic [31:0]       issue_pc;

   // Issue only when the buffer plus the in-flight read still has room after this cycle's dequeue.
   always_comb begin
      deq       = instr_valid & instr_ready;
      push      = inflight_valid & ~redirect_valid;
      occupancy = 3'(count) + 3'(inflight_valid);
      issue     = redirect_valid | (fetch_en & (occupancy < (3'd2 + 3'(deq))));
      issue_pc  = redirect_valid ? (redirect_pc & ~32'd3) : fetch_pc;
   end

   assign imem_addr   = issue_pc[ADDR_W+1:2];
   assign instr_valid = (count != 2'd0);
   assign instr       = fifo_instr[rd_ptr];
   assign instr_pc    = fifo_pc[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc       <= RESET_PC;
         inflight_valid <= 1'b0;
         inflight_pc    <= 32'd0;
         wr_ptr         <= 1'b0;
         rd_ptr         <= 1'b0;
         count          <= 2'd0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= 32'd0;
         end
      end else begin
         if (issue) begin
            inflight_valid <= 1'b1;
            inflight_pc    <= issue_pc;
            fetch_pc       <= issue_pc + 32'd4;
         end else begin
            inflight_valid <= 1'b0;
         end

         // Redirect flushes the buffer; the read landing this cycle belongs to the old path.
         if (redirect_valid) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (push) begin
               fifo_instr[wr_ptr] <= imem_dout;
               fifo_pc[wr_ptr]    <= inflight_pc;
               wr_ptr             <= ~wr_ptr;
            end
            if (deq) begin
               rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(deq);
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle table, async-reset sequence, and a randomized
// run checked against a stream-level model (in-order PCs, stall hold, redirect bubble).
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [9:0]  imem_addr;
   logic [31:0] imem_dout;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int compared   = 0;
   int mismatched = 0;

   ifetch_unit #(.ADDR_W(10), .DATA_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_dout(imem_dout),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   // IMEM preloaded with mem[k] = 0x1000_0000 + k, one-cycle synchronous read
   always @(posedge clk) imem_dout <= 32'h1000_0000 + 32'(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return 32'h1000_0000 + 32'(pc[11:2]);
   endfunction

   typedef struct {
      logic        fe, rdy, rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] ei, ep;
      logic [9:0]  ea;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t v(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                              input logic [9:0] ea);
      vec_t r;
      r.fe = fe; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
      r.ev = ev; r.ei = ei; r.ep = ep; r.ea = ea;
      return r;
   endfunction

   initial begin
      logic [31:0] exp_pc;
      logic        prev_stall, prev_redirect;
      logic [31:0] prev_instr, prev_pc;
      logic        fe_r, rdy_r, rv_r;
      logic [31:0] rpc_r;
      int          accepted;

      // cycle-by-cycle vectors from reset release: fill, stall, redirect, wrap, fetch_en gap
      tbl[0]  = v(1, 1, 0, 32'h0,   0, 32'h0,         32'h0,    10'd0);
      tbl[1]  = v(1, 1, 0, 32'h0,   0, 32'h0,         32'h0,    10'd1);
      tbl[2]  = v(1, 1, 0, 32'h0,   1, 32'h1000_0000, 32'h0,    10'd2);
      tbl[3]  = v(1, 1, 0, 32'h0,   1, 32'h1000_0001, 32'h4,    10'd3);
      tbl[4]  = v(1, 0, 0, 32'h0,   1, 32'h1000_0002, 32'h8,    10'd4);
      tbl[5]  = v(1, 0, 0, 32'h0,   1, 32'h1000_0002, 32'h8,    10'd4);
      tbl[6]  = v(1, 0, 1, 32'h100, 1, 32'h1000_0002, 32'h8,    10'd64);
      tbl[7]  = v(1, 1, 0, 32'h0,   0, 32'h0,         32'h0,    10'd65);
      tbl[8]  = v(1, 1, 0, 32'h0,   1, 32'h1000_0040, 32'h100,  10'd66);
      tbl[9]  = v(1, 1, 1, 32'hFF8, 1, 32'h1000_0041, 32'h104,  10'd1022);
      tbl[10] = v(1, 1, 0, 32'h0,   0, 32'h0,         32'h0,    10'd1023);
      tbl[11] = v(1, 1, 0, 32'h0,   1, 32'h1000_03FE, 32'hFF8,  10'd0);
      tbl[12] = v(1, 1, 0, 32'h0,   1, 32'h1000_03FF, 32'hFFC,  10'd1);
      tbl[13] = v(0, 1, 0, 32'h0,   1, 32'h1000_0000, 32'h1000, 10'd2);
      tbl[14] = v(0, 1, 0, 32'h0,   1, 32'h1000_0001, 32'h1004, 10'd2);
      tbl[15] = v(0, 1, 0, 32'h0,   0, 32'h0,         32'h0,    10'd2);
      tbl[16] = v(0, 1, 0, 32'h0,   0, 32'h0,         32'h0,    10'd2);
      tbl[17] = v(1, 1, 0, 32'h0,   0, 32'h0,         32'h0,    10'd2);
      tbl[18] = v(1, 1, 0, 32'h0,   0, 32'h0,         32'h0,    10'd3);
      tbl[19] = v(1, 1, 0, 32'h0,   1, 32'h1000_0002, 32'h1008, 10'd4);

      rst_n = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 32'(instr_valid), 32'd0);
      chk("reset_instr", instr, 32'd0);
      chk("reset_pc", instr_pc, 32'd0);
      chk("reset_addr", 32'(imem_addr), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         fetch_en = tbl[i].fe; instr_ready = tbl[i].rdy;
         redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(tbl[i].ea));
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_instr", i), instr, tbl[i].ei);
            chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].ep);
         end
         @(posedge clk);
         #1;
      end

      // asynchronous reset pulse between edges, mid-stream
      fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(instr_valid), 32'd0);
      chk("async_rst_addr", 32'(imem_addr), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rel_c0_valid", 32'(instr_valid), 32'd0);
      @(posedge clk); #1;
      chk("rel_c1_valid", 32'(instr_valid), 32'd0);
      @(posedge clk); #1;
      chk("rel_c2_valid", 32'(instr_valid), 32'd1);
      chk("rel_c2_instr", instr, 32'h1000_0000);
      chk("rel_c2_pc", instr_pc, 32'h0);

      // randomized run against the stream model
      exp_pc = 32'h0; prev_stall = 1'b0; prev_redirect = 1'b0;
      prev_instr = 32'h0; prev_pc = 32'h0; accepted = 0;
      for (int c = 0; c < 3000; c++) begin
         fe_r  = ($urandom_range(0, 3) != 0);
         rdy_r = ($urandom_range(0, 3) != 0);
         rv_r  = ($urandom_range(0, 15) == 0);
         rpc_r = $urandom;
         fetch_en = fe_r; instr_ready = rdy_r;
         redirect_valid = rv_r; redirect_pc = rpc_r;
         #1;
         if (prev_redirect) begin
            chk("rand_redirect_bubble", 32'(instr_valid), 32'd0);
         end else if (prev_stall) begin
            chk("rand_stall_valid", 32'(instr_valid), 32'd1);
            chk("rand_stall_instr", instr, prev_instr);
            chk("rand_stall_pc", instr_pc, prev_pc);
         end
         if (instr_valid) begin
            chk("rand_order_pc", instr_pc, exp_pc);
            chk("rand_data", instr, mem_word(exp_pc));
         end
         if (rv_r) chk("rand_redirect_addr", 32'(imem_addr), 32'(rpc_r[11:2]));

         prev_redirect = rv_r;
         prev_stall    = instr_valid & ~rdy_r & ~rv_r;
         prev_instr    = instr;
         prev_pc       = instr_pc;
         if (instr_valid && rdy_r) begin
            exp_pc = exp_pc + 32'd4;
            accepted++;
         end
         if (rv_r) exp_pc = rpc_r & ~32'd3;
         @(posedge clk);
         #1;
      end
      chk("rand_progress", 32'(accepted >= 600), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
